// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy playfield scroll logic.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } sched_state_t;

  localparam int ROWS_DEFAULT = 8;

  typedef logic [7:0] col_t;

endpackage

// File: rtl/pipe_scheduler_if.sv
// Bundle between the pipe scheduler, its pattern generator and the game logic.
// master = game/generator side, slave = the scheduler itself.
interface pipe_scheduler_if
  import flappy_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = ROWS_DEFAULT
) ();

  logic                 start;
  logic                 crash;
  logic [ROWS-1:0]      pattern;
  logic                 patReq;
  logic [COLS*ROWS-1:0] field;
  logic [ROWS-1:0]      birdCol;
  logic                 pipePass;
  logic                 running;

  modport master (
    output start,
    output crash,
    output pattern,
    input  patReq,
    input  field,
    input  birdCol,
    input  pipePass,
    input  running
  );

  modport slave (
    input  start,
    input  crash,
    input  pattern,
    output patReq,
    output field,
    output birdCol,
    output pipePass,
    output running
  );

endinterface

// File: rtl/tick_divider.sv
// Modulo-TICK_DIV cycle counter that marks the last cycle of each scroll period.
// The count is held while en is low, so a frozen game keeps its phase.
module tick_divider #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic Clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // Count cycles of the scroll period; clr restarts the period from zero.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Scroll controller for the Flappy playfield: shifts the pipe field left on
// every scroll tick and pulls a fresh gap pattern in every GAP-th tick.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = ROWS_DEFAULT,
  parameter int TICK_DIV = 25_000_000,
  parameter int GAP      = 4,
  parameter int BIRD_COL = 1
) (
  input logic             Clock,
  input logic             reset,
  pipe_scheduler_if.slave bus
);

  localparam int SW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SW-1:0] SPACE_LAST = SW'(GAP - 1);

  sched_state_t state, next_state;

  logic [SW-1:0]        spaceCnt;
  logic [COLS*ROWS-1:0] field_q;
  logic [ROWS-1:0]      new_col;
  logic                 pass_q;
  logic                 run_q;

  logic tick;
  logic div_en;
  logic div_clr;
  logic shift;
  logic insert;
  logic clear_field;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .Clock(Clock),
    .reset(reset),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  // Next-state and per-cycle control; crash wins over a coincident tick.
  always_comb begin
    next_state  = state;
    div_en      = 1'b0;
    div_clr     = 1'b0;
    shift       = 1'b0;
    insert      = 1'b0;
    clear_field = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = RUN;
          div_clr    = 1'b1;
        end
      end
      RUN: begin
        if (bus.crash) begin
          next_state = HALT;
        end else begin
          div_en = 1'b1;
          if (tick) begin
            shift  = 1'b1;
            insert = (spaceCnt == SPACE_LAST);
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          next_state  = RUN;
          div_clr     = 1'b1;
          clear_field = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign new_col      = insert ? bus.pattern : '0;
  assign bus.patReq   = reset && insert;
  assign bus.field    = field_q;
  assign bus.birdCol  = field_q[BIRD_COL*ROWS +: ROWS];
  assign bus.pipePass = pass_q;
  assign bus.running  = run_q;

  // State register, plus a registered copy of "in RUN" for the running output.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= next_state;
      run_q <= (next_state == RUN);
    end
  end

  // Spacing counter: an insertion happens when it reaches GAP-1, then restarts.
  always_ff @(posedge Clock) begin
    if (!reset || div_clr) begin
      spaceCnt <= SPACE_LAST;
    end else if (shift) begin
      spaceCnt <= insert ? '0 : spaceCnt + 1'b1;
    end
  end

  // Field shift register: column c takes c+1, the new column enters on the right.
  always_ff @(posedge Clock) begin
    if (!reset || clear_field) begin
      field_q <= '0;
    end else if (shift) begin
      field_q <= {new_col, field_q[COLS*ROWS-1:ROWS]};
    end
  end

  // Pipe-passed strobe: the bird column was occupied just before this shift.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= shift && (|field_q[BIRD_COL*ROWS +: ROWS]);
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler with a scoreboard of expected pipe passes.
module tb_pipe_scheduler;
  import flappy_pkg::*;

  localparam int COLS     = 8;
  localparam int ROWS     = 8;
  localparam int TICK_DIV = 4;
  localparam int GAP      = 3;
  localparam int BIRD_COL = 1;
  localparam int FW       = COLS * ROWS;

  logic Clock;
  logic reset;

  pipe_scheduler_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  pipe_scheduler #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .TICK_DIV(TICK_DIV),
    .GAP     (GAP),
    .BIRD_COL(BIRD_COL)
  ) dut (
    .Clock(Clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  sched_state_t    m_state = IDLE;
  int              m_cyc   = 0;
  int              m_tick  = 0;
  logic [FW-1:0]   m_field = '0;
  logic            m_pass  = 1'b0;
  int              passq[$];
  logic [FW-1:0]   saved_field;

  // Free-running clock, 10 time units per cycle.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic rst_v, input logic start_v, input logic crash_v);
    reset     = rst_v;
    bus.start = start_v;
    bus.crash = crash_v;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic exp_req;
    exp_req = reset && (m_state == RUN) && !bus.crash &&
              (m_cyc == TICK_DIV - 1) && ((m_tick % GAP) == 0);
    checkVal("patReq",   64'(bus.patReq),   64'(exp_req));
    checkVal("running",  64'(bus.running),  64'(m_state == RUN));
    checkVal("field",    64'(bus.field),    64'(m_field));
    checkVal("birdCol",  64'(bus.birdCol),  64'(m_field[BIRD_COL*ROWS +: ROWS]));
    checkVal("pipePass", 64'(bus.pipePass), 64'(m_pass));
  endtask

  // Reference behaviour advanced once per rising edge from the inputs just applied.
  task automatic updateModel();
    logic [ROWS-1:0] new_col;
    m_pass = 1'b0;
    if (!reset) begin
      m_state = IDLE;
      m_field = '0;
      m_cyc   = 0;
      m_tick  = 0;
      passq.delete();
    end else begin
      case (m_state)
        IDLE: begin
          if (bus.start) begin
            m_state = RUN;
            m_cyc   = 0;
            m_tick  = 0;
          end
        end
        RUN: begin
          if (bus.crash) begin
            m_state = HALT;
          end else if (m_cyc == TICK_DIV - 1) begin
            m_cyc = 0;
            m_tick++;
            if (passq.size() > 0 && passq[0] == m_tick) begin
              m_pass = 1'b1;
              void'(passq.pop_front());
            end
            new_col = (((m_tick - 1) % GAP) == 0) ? bus.pattern : '0;
            m_field = {new_col, m_field[FW-1:ROWS]};
            if (new_col != '0) passq.push_back(m_tick + COLS - BIRD_COL);
          end else begin
            m_cyc++;
          end
        end
        HALT: begin
          if (bus.start) begin
            m_state = RUN;
            m_field = '0;
            m_cyc   = 0;
            m_tick  = 0;
            passq.delete();
          end
        end
        default: m_state = IDLE;
      endcase
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      #2;
      checkOutput();
      @(posedge Clock);
      updateModel();
      #1;
    end
  endtask

  initial begin
    // Reset held for two edges with start high.
    bus.pattern = 8'hC7;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge Clock);
      updateModel();
    end
    #1;
    checkOutput();
    checkVal("reset_state", 64'(dut.state), 64'(IDLE));
    applyStimulus(1'b1, 1'b0, 1'b0);
    runCycles(1);

    // First insertion on the fourth RUN cycle.
    applyStimulus(1'b1, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkVal("run_after_start", 64'(bus.running), 64'd1);
    runCycles(3);
    checkVal("first_patreq", 64'(bus.patReq), 64'd1);
    runCycles(1);
    checkVal("first_insert", 64'(bus.field), 64'hC700_0000_0000_0000);

    // Scroll through tick 8: bird column and pipe-passed strobe.
    runCycles(24);
    checkVal("bird_after_t7", 64'(bus.birdCol), 64'hC7);
    runCycles(4);
    checkVal("pass_after_t8", 64'(bus.pipePass), 64'd1);
    runCycles(1);
    checkVal("pass_one_cycle", 64'(bus.pipePass), 64'd0);

    // Crash in the tick-10 cycle, which would otherwise insert.
    runCycles(6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    saved_field = bus.field;
    #1;
    checkVal("crash_no_req", 64'(bus.patReq), 64'd0);
    runCycles(1);
    checkVal("crash_halt", 64'(bus.running), 64'd0);
    checkVal("crash_no_shift", 64'(bus.field), 64'(saved_field));
    runCycles(20);
    checkVal("halt_frozen", 64'(bus.field), 64'(saved_field));

    // Restart from HALT.
    applyStimulus(1'b1, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkVal("restart_clear", 64'(bus.field), 64'd0);
    checkVal("restart_run", 64'(bus.running), 64'd1);
    runCycles(3);
    checkVal("restart_patreq", 64'(bus.patReq), 64'd1);
    runCycles(1);
    checkVal("restart_insert", 64'(bus.field), 64'hC700_0000_0000_0000);

    // Reset mid-scroll, with start high to show reset wins.
    runCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkVal("rst_field", 64'(bus.field), 64'd0);
    checkVal("rst_running", 64'(bus.running), 64'd0);
    checkVal("rst_pass", 64'(bus.pipePass), 64'd0);
    runCycles(2);

    // Start again behaves like a fresh game.
    applyStimulus(1'b1, 1'b1, 1'b0);
    runCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkVal("again_run", 64'(bus.running), 64'd1);
    runCycles(3);
    checkVal("again_patreq", 64'(bus.patReq), 64'd1);
    runCycles(1);
    checkVal("again_insert", 64'(bus.field), 64'hC700_0000_0000_0000);

    // An all-zero pattern at tick 4 goes in as an empty column.
    runCycles(11);
    bus.pattern = 8'h00;
    #1;
    checkVal("zero_patreq", 64'(bus.patReq), 64'd1);
    runCycles(1);
    checkVal("zero_col7", 64'(bus.field[FW-1 -: ROWS]), 64'd0);
    bus.pattern = 8'hC7;
    runCycles(12);
    checkVal("after_zero_col7", 64'(bus.field[FW-1 -: ROWS]), 64'hC7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
